// File: rtl/mmio_uart_tx_if.sv
// Processor load/store port used by the memory-mapped UART transmitter.
// The master drives the strobes, address and store data; the slave returns load data.
interface mmio_uart_tx_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output mem_write, mem_read, address, write_data,
    input  read_data
  );

  modport slave (
    input  mem_write, mem_read, address, write_data,
    output read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO and a sticky
// overflow flag, readable through a status register.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 8,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0104
) (
  input  logic             clk,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             tx,
  output logic             tx_busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   clk_cnt, clk_cnt_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [7:0]      shreg, shreg_next;
  logic            tx_next;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            fifo_empty, fifo_full;
  logic            overflow;

  logic            push_req, push, pop, stat_write, bit_done;
  logic            unused_upper;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign bit_done   = (clk_cnt == CLK_LAST);

  assign push_req   = bus.mem_write && (bus.address == TX_ADDR);
  assign stat_write = bus.mem_write && (bus.address == STAT_ADDR);
  // A full FIFO still accepts a store on the edge that frees the head slot.
  assign push       = push_req && (!fifo_full || pop);

  assign unused_upper = ^bus.write_data[31:8];

  assign tx_busy       = (state != IDLE) || !fifo_empty;
  assign bus.read_data = (bus.mem_read && (bus.address == STAT_ADDR))
                         ? {28'b0, overflow, fifo_empty, fifo_full, tx_busy}
                         : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the upcoming state so the line changes on the same
  // edge as the state does.
  always_comb begin
    pop          = 1'b0;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_next   = fifo_mem[rd_ptr];
          clk_cnt_next = '0;
          bit_cnt_next = '0;
        end
      end
      START, STOP: clk_cnt_next = bit_done ? '0 : clk_cnt + CW'(1);
      DATA: begin
        clk_cnt_next = bit_done ? '0 : clk_cnt + CW'(1);
        if (bit_done) begin
          bit_cnt_next = bit_cnt + 3'd1;
          shreg_next   = shreg >> 1;
        end
      end
      default: ;
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (stat_write)               overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr] <= bus.write_data[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random traffic, compared each
// cycle against a queue-based model of the FIFO and the serial frame timing.
module tb_mmio_uart_tx;
  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] TXA  = 32'h0000_0100;
  localparam logic [31:0] STA  = 32'h0000_0104;
  localparam logic [31:0] OTHR = 32'h0000_0108;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT(C), .FIFO_DEPTH(D), .TX_ADDR(TXA), .STAT_ADDR(STA)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: byte queue, sticky overflow, and cycles remaining in the current frame.
  logic [7:0] mq[$];
  bit         m_ovf  = 1'b0;
  int         m_left = 0;
  logic [7:0] m_cur  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_tx();
    int idx;
    if (m_left == 0) return 1'b1;
    idx = (10 * C - m_left) / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic m_busy();
    return (m_left != 0) || (mq.size() != 0);
  endfunction

  function automatic logic [31:0] m_rd();
    logic [31:0] s;
    s = {28'b0, m_ovf, mq.size() == 0, mq.size() == D, m_busy()};
    return (bus.mem_read && bus.address == STA) ? s : 32'b0;
  endfunction

  task automatic model_edge();
    int sz;
    bit pop;
    if (reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_left = 0;
      return;
    end
    sz  = mq.size();
    pop = (m_left == 0) && (sz != 0);
    if (pop) begin
      m_cur  = mq.pop_front();
      m_left = 10 * C;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (bus.mem_write && bus.address == TXA) begin
      if (sz < D || pop) mq.push_back(bus.write_data[7:0]);
      else               m_ovf = 1'b1;
    end
    if (bus.mem_write && bus.address == STA) m_ovf = 1'b0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_tx"},   {31'b0, tx},      {31'b0, m_tx()});
    check({tag, "_busy"}, {31'b0, tx_busy}, {31'b0, m_busy()});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic bus_idle();
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.address    = 32'b0;
    bus.write_data = 32'b0;
  endtask

  task automatic write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_write  = 1'b1;
    bus.address    = addr;
    bus.write_data = data;
    tick(tag);
    bus_idle();
  endtask

  task automatic read_chk(input string tag, input logic rd, input logic [31:0] addr,
                          input logic [31:0] exp);
    bus.mem_read = rd;
    bus.address  = addr;
    #1;
    check(tag, bus.read_data, exp);
    check({tag, "_model"}, bus.read_data, m_rd());
    bus_idle();
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    run("reset", 2);
    reset = 1'b0;
    tick("post_reset");
    check("reset_busy", {31'b0, tx_busy}, 32'h0);
    read_chk("reset_stat", 1'b1, STA, 32'h4);

    // Single byte 0x55: start bit right after the push edge, busy drops after STOP.
    write("w55", TXA, 32'h55);
    tick("w55_e1");
    check("w55_start_low", {31'b0, tx}, 32'h0);
    run("w55_frame", 39);
    check("w55_busy_in_stop", {31'b0, tx_busy}, 32'h1);
    tick("w55_e41");
    check("w55_busy_fall", {31'b0, tx_busy}, 32'h0);
    run("w55_idle", 3);

    // Upper store bits are ignored.
    write("wa5", TXA, 32'hFFFF_FFA5);
    run("wa5_frame", 45);

    // Six back-to-back stores: five sent, sixth dropped, overflow sticky until cleared.
    for (int i = 1; i <= 6; i++) write("burst", TXA, 32'(i));
    read_chk("burst_stat_ovf", 1'b1, STA, 32'hB);
    run("burst_frames", 210);
    read_chk("burst_stat_drained", 1'b1, STA, 32'hC);
    write("stat_clr", STA, $urandom());
    read_chk("stat_cleared", 1'b1, STA, 32'h4);

    // Status decode.
    write("w3c", TXA, 32'h3C);
    read_chk("stat_after_push", 1'b1, STA, 32'h1);
    read_chk("read_other_addr", 1'b1, OTHR, 32'h0);
    read_chk("stat_no_read", 1'b0, STA, 32'h0);
    run("w3c_frame", 45);

    // Push on the pop edge of a full FIFO.
    for (int i = 0; i < 5; i++) write("fill", TXA, $urandom());
    read_chk("fill_full", 1'b1, STA, 32'h3);
    for (int k = 0; k < 60 && m_left != 0; k++) tick("wait_pop");
    write("push_on_pop", TXA, 32'h77);
    read_chk("push_on_pop_stat", 1'b1, STA, 32'h3);
    run("fill_drain", 215);

    // Reset during data bit 3 with two bytes queued.
    for (int i = 0; i < 3; i++) write("rq", TXA, $urandom());
    for (int k = 0; k < 60 && !(m_left != 0 && (10 * C - m_left) / C == 4); k++) tick("wait_bit3");
    reset = 1'b1;
    tick("mid_reset");
    check("mid_reset_tx", {31'b0, tx}, 32'h1);
    reset = 1'b0;
    read_chk("mid_reset_stat", 1'b1, STA, 32'h4);
    run("after_reset_quiet", 100);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      bus.mem_write  = (r < 4);
      bus.address    = (r < 3) ? TXA : (r == 3) ? (($urandom_range(0, 1) != 0) ? STA : OTHR)
                                    : (($urandom_range(0, 1) != 0) ? STA : OTHR);
      bus.write_data = $urandom();
      bus.mem_read   = ($urandom_range(0, 1) != 0);
      #1;
      check("rand_rdata", bus.read_data, m_rd());
      tick("rand");
      bus_idle();
    end
    run("final_drain", 250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clock cycles per serial bit; legal values are 2 or greater.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; must be a power of two, 2 or greater.
REQ-003 Parameter TX_ADDR, default 32'h0000_0100: data register address (write-only).
REQ-004 Parameter STAT_ADDR, default 32'h0000_0104: status register address (read; write clears overflow).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mem_write  input  1  processor store strobe, one cycle per store.
REQ-008 mem_read  input  1  processor load strobe.
REQ-009 address  input  32  processor data address.
REQ-010 write_data  input  32  processor store data.
REQ-011 read_data  output  32  load data, combinational.
REQ-012 tx  output  1  serial line, registered, idle high.
REQ-013 tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-014 mem_write with address==TX_ADDR and FIFO not full SHALL push write_data[7:0]; bits [31:8] are ignored.
REQ-015 A push while full SHALL be dropped and SHALL set sticky overflow, except when a pop occurs on the same edge, in which case the push is accepted and count is unchanged.
REQ-016 mem_write to STAT_ADDR SHALL clear overflow regardless of data; writes to other addresses SHALL have no effect.
REQ-017 read_data SHALL be {28'b0, overflow, fifo_empty, fifo_full, tx_busy} when mem_read and address==STAT_ADDR, otherwise 32'b0.
REQ-018 FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop the head into the shift register, clear the bit counter and cycle counter, go to START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit 7, go to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, with at least one IDLE cycle between consecutive frames.
REQ-024 Latency: for a push at edge E0 into an empty FIFO with the FSM in IDLE, the pop occurs at E1 and tx SHALL go low after E1.
REQ-025 FIFO order SHALL be strict first-in, first-out.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Occupancy count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 Cycle and bit counters SHALL be sized by $clog2 and SHALL NOT overflow at CLKS_PER_BIT-1.
REQ-029 tx_busy SHALL equal (state!=IDLE) OR !fifo_empty, derived combinationally from registered state.

Reset
REQ-030 On reset sampled high: state=IDLE, tx=1, FIFO empty (pointers and count=0), overflow=0, all counters=0, shift register=0.
REQ-031 Reset SHALL take priority over any simultaneous write or pop.
REQ-032 Reset mid-frame SHALL abort the frame; tx=1 after that edge and no residual bits are sent.
REQ-033 After reset releases, tx_busy=0 and a STAT read returns 32'h4.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single write of 0x55 from idle -> tx low for 4 cycles starting one cycle after the push edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4 cycles; frame is 40 cycles; tx_busy falls after STOP.
REQ-035 Write of 32'hFFFF_FFA5 -> serial byte 0xA5 (bits 1,0,1,0,0,1,0,1); upper bits never appear.
REQ-036 Six writes on consecutive cycles from idle, data 0x01..0x06 -> 0x01..0x05 transmitted in order with one idle cycle between frames; 0x06 dropped; STAT bit3=1 until a STAT write, then 0.
REQ-037 STAT read one cycle after a TX write -> 32'h1 (busy, not empty, not full); read of address 0x108 -> 0; STAT read with mem_read=0 -> 0.
REQ-038 Reset asserted during DATA bit 3 with two bytes queued -> tx=1 from the next edge, STAT reads 32'h4, and no further frames follow.
REQ-039 Push on the same edge the FSM pops from a full FIFO -> push accepted, count stays 4, overflow stays 0.
